// File: rtl/ascensor_floor_ctrl_pkg.sv
// Shared types and constants for the elevator floor-counter controller.
package ascensor_pkg;

    localparam int FLOOR_W = 4;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_INIT = 3'd1,
        S_IDLE = 3'd2,
        S_MOVE = 3'd3,
        S_DOOR = 3'd4
    } st_t;

    // Width of the shared pace timer: it must reach max(travel, door) - 1.
    function automatic int tmr_width(input int travel, input int door);
        int m;
        m = (travel > door) ? travel : door;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ascensor_floor_ctrl_if.sv
// Floor-request valid/ready handshake between call logic and the controller.
interface ascensor_floor_ctrl_if;
    import ascensor_pkg::*;

    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ready;

    modport master (output req_valid, output req_floor, input req_ready);
    modport slave  (input req_valid, input req_floor, output req_ready);
endinterface

// File: rtl/ascensor_floor_ctrl_pace_timer.sv
// Clearable modulo counter; tc_o flags the terminal value last_i.
module pace_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic [W-1:0] last_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == last_i);

    // Restart on clear, wrap after the terminal value, otherwise advance.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tc_o) cnt_d = '0;
    end

    // Timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ascensor_floor_ctrl.sv
// Sequences the elevator floor counter: home load, paced stepping, door hold.
module ascensor_floor_ctrl
    import ascensor_pkg::*;
#(
    parameter int NUM_FLOORS    = 16,
    parameter int HOME_FLOOR    = 0,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ascensor_floor_ctrl_if.slave req,
    output logic               cnt_enb,
    output logic               cnt_modo,
    output logic               cnt_dir,
    output logic [FLOOR_W-1:0] cnt_data,
    input  logic [FLOOR_W-1:0] cnt_q,
    output logic               moving,
    output logic               door_open,
    output logic               done,
    output logic               err
);
    localparam int TW = tmr_width(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam logic [TW-1:0]      TRV_LAST  = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]      DOOR_LAST = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] HOME_L    = FLOOR_W'(HOME_FLOOR);
    localparam logic [FLOOR_W-1:0] TOP_L     = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W:0]   NF_L      = (FLOOR_W + 1)'(NUM_FLOORS);

    st_t                state_q, state_d;
    logic [FLOOR_W-1:0] target_q, target_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               tmr_tc;
    logic               tmr_clr;
    logic [TW-1:0]      tmr_last;
    logic               accept;
    logic               at_target;
    logic               step_ok;
    logic               step;

    assign req.req_ready = (state_q == S_IDLE);
    assign accept        = (state_q == S_IDLE) && req.req_valid;
    assign at_target     = (cnt_q == target_q);
    // Never step past the top floor or below floor 0, even if the counter misbehaves.
    assign step_ok       = dir_q ? (cnt_q != TOP_L) : (cnt_q != '0);
    assign step          = (state_q == S_MOVE) && tmr_tc && !at_target && step_ok;
    assign tmr_clr       = (state_d != state_q);
    assign tmr_last      = (state_q == S_MOVE) ? TRV_LAST : DOOR_LAST;
    assign err           = err_q;

    pace_timer #(.W(TW)) u_pace (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmr_clr),
        .last_i (tmr_last),
        .tc_o   (tmr_tc)
    );

    // Next-state logic: request acceptance, arrival and door timeout.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        err_d    = 1'b0;
        case (state_q)
            S_RST:  state_d = S_INIT;
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    target_d = req.req_floor;
                    if ({1'b0, req.req_floor} >= NF_L) begin
                        err_d = 1'b1;
                    end else if (req.req_floor == cnt_q) begin
                        state_d = S_DOOR;
                    end else begin
                        state_d = S_MOVE;
                        dir_d   = (req.req_floor > cnt_q);
                    end
                end
            end
            S_MOVE: if (at_target) state_d = S_DOOR;
            S_DOOR: if (tmr_tc) state_d = S_IDLE;
            default: state_d = S_RST;
        endcase
    end

    // Control state, asynchronously returned to S_RST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Request data; only meaningful once a request has been accepted.
    always_ff @(posedge clk) begin
        target_q <= target_d;
        dir_q    <= dir_d;
    end

    // Output decode from registered state, pace timer and counter value.
    always_comb begin
        cnt_enb   = 1'b0;
        cnt_modo  = 1'b0;
        cnt_dir   = 1'b0;
        cnt_data  = '0;
        moving    = 1'b0;
        door_open = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_INIT: begin
                cnt_enb  = 1'b1;
                cnt_modo = 1'b1;
                cnt_data = HOME_L;
            end
            S_IDLE: cnt_data = HOME_L;
            S_MOVE: begin
                cnt_data = HOME_L;
                moving   = 1'b1;
                if (step) begin
                    cnt_enb = 1'b1;
                    cnt_dir = dir_q;
                end
            end
            S_DOOR: begin
                cnt_data  = HOME_L;
                door_open = 1'b1;
                done      = tmr_tc;
            end
            default: ;
        endcase
    end
endmodule
